// File: rtl/mult_frame_acc.sv
// Frame accumulator behind the signed multiplier: sums frame_len products per frame
// and holds each sum in a one-entry valid/ready output register.
// Optional saturating adds: define MULT_FRAME_ACC_SAT_EN (default build wraps).
module mult_frame_acc #(
    parameter int unsigned IN_W  = 9,
    parameter int unsigned ACC_W = 16,
    parameter int unsigned LEN_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  in_data,
    input  logic [LEN_W-1:0]        frame_len,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_data,
    output logic                    out_ovf,
    output logic                    overrun,
    output logic                    busy
);

    localparam int unsigned SUM_W = ACC_W + 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_ACC  = 1'b1;

`ifdef MULT_FRAME_ACC_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

    logic signed [ACC_W-1:0] acc_q, acc_n;
    logic [LEN_W-1:0]        cnt_q, cnt_n;
    logic [LEN_W-1:0]        len_q, len_n;
    logic                    ovf_q, ovf_n;

    logic                    out_valid_n;
    logic signed [ACC_W-1:0] out_data_n;
    logic                    out_ovf_n;
    logic                    overrun_n;

    logic [0:0]              state_c;
    logic signed [SUM_W-1:0] ext_c;
    logic signed [SUM_W-1:0] sum_c;
    logic                    add_ovf_c;
    logic signed [ACC_W-1:0] res_c;
    logic [LEN_W-1:0]        len_eff_c;
    logic                    last_c;
    logic                    done_c;

    // Adder datapath; acc is always zero in IDLE so the first product shares the same path.
    always_comb begin
        ext_c     = SUM_W'(in_data);
        sum_c     = SUM_W'(acc_q) + ext_c;
        add_ovf_c = sum_c[SUM_W-1] != sum_c[SUM_W-2];
`ifdef MULT_FRAME_ACC_SAT_EN
        if (add_ovf_c) begin
            res_c = sum_c[SUM_W-1] ? ACC_MIN : ACC_MAX;
        end else begin
            res_c = sum_c[ACC_W-1:0];
        end
`else
        res_c = sum_c[ACC_W-1:0];
`endif
    end

    // Next-state and output logic; state is decoded from the product counter.
    always_comb begin
        acc_n       = acc_q;
        cnt_n       = cnt_q;
        len_n       = len_q;
        ovf_n       = ovf_q;
        out_valid_n = out_valid;
        out_data_n  = out_data;
        out_ovf_n   = out_ovf;
        overrun_n   = 1'b0;
        done_c      = 1'b0;
        last_c      = 1'b0;

        state_c   = (cnt_q != '0) ? S_ACC : S_IDLE;
        len_eff_c = (frame_len == '0) ? LEN_W'(1) : frame_len;

        if (in_valid) begin
            case (state_c)
                S_IDLE: begin
                    len_n  = len_eff_c;
                    last_c = (len_eff_c == LEN_W'(1));
                end
                S_ACC: begin
                    last_c = (cnt_q == LEN_W'(len_q - LEN_W'(1)));
                end
                default: begin
                    last_c = 1'b0;
                end
            endcase

            if (last_c) begin
                done_c = 1'b1;
                acc_n  = '0;
                cnt_n  = '0;
                ovf_n  = 1'b0;
            end else begin
                acc_n = res_c;
                cnt_n = LEN_W'(cnt_q + LEN_W'(1));
                ovf_n = ovf_q | add_ovf_c;
            end
        end

        // A completion always loads; it only counts as overrun if the old sum was refused.
        if (done_c) begin
            out_valid_n = 1'b1;
            out_data_n  = res_c;
            out_ovf_n   = ovf_q | add_ovf_c;
            overrun_n   = out_valid & ~out_ready;
        end else if (out_valid && out_ready) begin
            out_valid_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            len_q     <= '0;
            ovf_q     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            acc_q     <= acc_n;
            cnt_q     <= cnt_n;
            len_q     <= len_n;
            ovf_q     <= ovf_n;
            out_valid <= out_valid_n;
            out_data  <= out_data_n;
            out_ovf   <= out_ovf_n;
            overrun   <= overrun_n;
            busy      <= (cnt_n != '0);
        end
    end

endmodule

// File: tb/tb_mult_frame_acc.sv
// Scoreboard bench for mult_frame_acc: stimulus pushes expected frame sums,
// a negedge monitor pops and compares on every output handshake.
module tb_mult_frame_acc;

    localparam int unsigned IN_W  = 9;
    localparam int unsigned ACC_W = 16;
    localparam int unsigned LEN_W = 8;

    typedef struct packed {
        logic signed [ACC_W-1:0] data;
        logic                    ovf;
    } exp_t;

    logic                    clk;
    logic                    rst;
    logic                    in_valid;
    logic signed [IN_W-1:0]  in_data;
    logic [LEN_W-1:0]        frame_len;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_data;
    logic                    out_ovf;
    logic                    overrun;
    logic                    busy;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    mult_frame_acc #(.IN_W(IN_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .frame_len (frame_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int d);
        in_valid = v;
        in_data  = IN_W'(d);
        tick();
    endtask

    task automatic push(input int d, input logic o);
        exp_t e;
        e.data = ACC_W'(d);
        e.ovf  = o;
        exp_q.push_back(e);
    endtask

    // Monitor: every accepted sum must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual=%0d expected=none", out_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_data", int'(out_data), int'(e.data));
                chk("sb_ovf", int'(out_ovf), int'(e.ovf));
            end
        end
    end

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        frame_len = '0;
        out_ready = 1'b0;
        repeat (3) tick();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_ovf", int'(out_ovf), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_busy", int'(busy), 0);

        // Basic frame of 4
        rst       = 1'b1;
        frame_len = 8'd4;
        out_ready = 1'b1;
        push(7, 1'b0);
        drive(1'b1, 3);
        chk("t1_busy", int'(busy), 1);
        drive(1'b1, -5);
        drive(1'b1, 7);
        chk("t1_valid_early", int'(out_valid), 0);
        drive(1'b1, 2);
        chk("t1_latency", int'(out_valid), 1);
        chk("t1_busy_done", int'(busy), 0);
        drive(1'b0, 0);
        chk("t1_valid_drop", int'(out_valid), 0);

        // Length 0 treated as 1, then back-to-back single-product frames
        frame_len = 8'd0;
        push(-9, 1'b0);
        drive(1'b1, -9);
        chk("t2_len0_valid", int'(out_valid), 1);
        chk("t2_len0_busy", int'(busy), 0);
        frame_len = 8'd1;
        push(-9, 1'b0);
        push(4, 1'b0);
        push(-256, 1'b0);
        drive(1'b1, -9);
        drive(1'b1, 4);
        drive(1'b1, -256);
        drive(1'b0, 0);
        chk("t2_idle", int'(out_valid), 0);

        // Held output overwritten by next completion
        frame_len = 8'd3;
        out_ready = 1'b0;
        drive(1'b1, 1);
        drive(1'b1, 1);
        drive(1'b1, 1);
        chk("t3_first_data", int'(out_data), 3);
        drive(1'b0, 0);
        drive(1'b0, 0);
        chk("t3_hold_data", int'(out_data), 3);
        chk("t3_hold_valid", int'(out_valid), 1);
        chk("t3_no_overrun", int'(overrun), 0);
        drive(1'b1, 2);
        drive(1'b1, 2);
        drive(1'b1, 2);
        chk("t3_overrun", int'(overrun), 1);
        chk("t3_second_data", int'(out_data), 6);
        drive(1'b0, 0);
        chk("t3_overrun_pulse", int'(overrun), 0);
        push(6, 1'b0);
        out_ready = 1'b1;
        tick();
        chk("t3_drained", int'(out_valid), 0);

        // Accept on the completion cycle: no overrun
        out_ready = 1'b0;
        push(3, 1'b0);
        push(6, 1'b0);
        drive(1'b1, 1);
        drive(1'b1, 1);
        drive(1'b1, 1);
        drive(1'b1, 2);
        drive(1'b1, 2);
        out_ready = 1'b1;
        drive(1'b1, 2);
        chk("t3b_no_overrun", int'(overrun), 0);
        chk("t3b_valid", int'(out_valid), 1);
        drive(1'b0, 0);

        // Overflow: 200 x 255 = 51000 exceeds the 16-bit range
        frame_len = 8'd200;
`ifdef MULT_FRAME_ACC_SAT_EN
        push(32767, 1'b1);
`else
        push(51000 - 65536, 1'b1);
`endif
        for (int i = 0; i < 200; i++) drive(1'b1, 255);
        drive(1'b0, 0);

        // Gaps inside a frame; a mid-frame length change applies to the next frame only
        frame_len = 8'd4;
        push(32, 1'b0);
        drive(1'b1, 10);
        frame_len = 8'd2;
        drive(1'b0, 0);
        drive(1'b0, 0);
        chk("t5_busy_gap", int'(busy), 1);
        drive(1'b1, -3);
        drive(1'b1, 20);
        drive(1'b0, 0);
        chk("t5_not_done", int'(out_valid), 0);
        drive(1'b1, 5);
        chk("t5_done", int'(out_valid), 1);
        push(13, 1'b0);
        drive(1'b1, 6);
        drive(1'b1, 7);
        drive(1'b0, 0);

        // Reset mid-frame with a held output
        out_ready = 1'b0;
        frame_len = 8'd1;
        drive(1'b1, 50);
        frame_len = 8'd4;
        drive(1'b1, 100);
        drive(1'b1, 100);
        chk("t6_pre_valid", int'(out_valid), 1);
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("t6_rst_valid", int'(out_valid), 0);
        chk("t6_rst_data", int'(out_data), 0);
        chk("t6_rst_ovf", int'(out_ovf), 0);
        chk("t6_rst_overrun", int'(overrun), 0);
        chk("t6_rst_busy", int'(busy), 0);
        rst       = 1'b1;
        out_ready = 1'b1;
        push(10, 1'b0);
        drive(1'b1, 1);
        drive(1'b1, 2);
        drive(1'b1, 3);
        drive(1'b1, 4);
        drive(1'b0, 0);
        repeat (3) tick();

        chk("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_frame_acc.md
Name: mult_frame_acc

Overview:
- Downstream stage of the pipelined signed multiplier.
- Consumes its product stream (valid-only, no backpressure) and sums FRAME products per frame.
- Presents each frame sum on a one-entry valid/ready output register.
- Used as the dot-product / MAC back end behind the multiplier pipeline.

Parameters:
- IN_W, 9, width of signed product input (multiplier M+N).
- ACC_W, 16, width of signed accumulator and output; must be >= IN_W.
- LEN_W, 8, width of frame length input.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-low; asserted when rst==0, sampled on the clk rising edge.
- in_valid  input  1  product valid, from multiplier mult_out_valid.
- in_data  input  IN_W  signed product, two's complement, from multiplier mult_out.
- frame_len  input  LEN_W  products per frame; value 0 is treated as 1.
- out_valid  output  1  frame sum available.
- out_ready  input  1  downstream accepts sum.
- out_data  output  ACC_W  signed frame sum.
- out_ovf  output  1  qualifies out_data: overflow occurred in this frame.
- overrun  output  1  one-cycle pulse: completed sum overwrote an unaccepted sum.
- busy  output  1  frame in progress (cnt != 0).

Behaviour:
- Reset (rst==0 at clk edge): acc=0, cnt=0, ovf_acc=0, out_valid=0, out_data=0, out_ovf=0, overrun=0, len_q=0.
- Reset mid-frame discards the partial sum and any held output.
- Input is never stalled; in_valid is honoured every cycle it is high.
- in_data is sign-extended to ACC_W+1 bits before adding.
- Two states, decoded from cnt:
  - IDLE: cnt==0.
  - ACC: cnt!=0.
- IDLE, in_valid=1:
  - Latch len_q = max(frame_len,1). frame_len is sampled only here; changes mid-frame are ignored.
  - If len_q==1: frame completes this cycle.
  - Else: acc=ext(in_data), cnt=1, go to ACC.
- ACC, in_valid=1:
  - sum = acc + ext(in_data).
  - If cnt==len_q-1: frame completes; cnt=0, acc=0.
  - Else: acc=sum, cnt=cnt+1.
- in_valid=0: no state change; gaps inside a frame are allowed.
- Overflow:
  - Detected per add when the (ACC_W+1)-bit sum is not representable in ACC_W bits.
  - ovf_acc is the sticky OR of per-add overflow over the frame, cleared at frame completion.
- Completion, at the edge following the last in_valid cycle:
  - out_data = final sum (per the Optional Feature rule).
  - out_ovf = ovf_acc | final-add overflow.
  - out_valid=1.
  - Latency: last product to out_valid = 1 cycle.
- Output handshake:
  - out_data and out_ovf are stable while out_valid=1 and out_ready=0.
  - out_valid && out_ready, no completion: out_valid=0 next cycle.
  - Completion and out_valid && out_ready in the same cycle: new sum loaded, out_valid stays 1, no overrun.
  - Completion while out_valid && !out_ready: new sum overwrites, overrun=1 for one cycle.
  - out_ready while out_valid=0 is ignored.
- Back-to-back frames: a new frame may start the cycle after completion with no bubble.

Optional Feature:
- Macro: MULT_FRAME_ACC_SAT_EN.
- Defined:
  - Each add saturates to +(2^(ACC_W-1)-1) or -(2^(ACC_W-1)) on overflow.
  - Accumulation continues from the clamped value.
  - out_ovf=1 if any clamp occurred in the frame.
- Undefined:
  - Adds wrap modulo 2^ACC_W.
  - out_ovf=1 if any wrap occurred in the frame.

Test Plan:
- Reset then frame_len=4, out_ready=1, in_data 3,-5,7,2 on consecutive cycles -> out_valid one cycle after the 4th input, out_data=7, out_ovf=0.
- frame_len=0, in_data=-9 single pulse -> out_data=-9 next cycle; with frame_len=1 the same result; frames back-to-back every cycle.
- frame_len=3, out_ready=0, two frames 1,1,1 then 2,2,2 -> first out_data=3 held stable; second completion gives out_data=6 and a one-cycle overrun; raising out_ready on the completion cycle instead gives no overrun.
- ACC_W=10, IN_W=9, frame_len=3, in_data 255,255,255 -> SAT_EN: out_data=511, out_ovf=1; without: out_data=-259 (765 mod 1024 → -259), out_ovf=1.
- frame_len=4 with in_valid gaps (1,0,0,1,1,0,1), frame_len changed to 2 mid-frame -> single sum of 4 products; new length used on next frame only.
- rst=0 asserted after 2 of 4 products with out_valid=1 held -> all outputs 0 next cycle; the next 4 products produce a sum excluding the discarded data.
